// File: rtl/instr_buffer.sv
// Decode-side instruction buffer: a DEPTH-entry circular FIFO of {instr, pc} pairs with
// first-word-fall-through output, fetch backpressure and a branch-redirect flush.
module instr_buffer #(
  parameter type         T     = logic [31:0],
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  T                           instr_in,
  input  T                           pc_in,
  input  logic                       valid_in,
  output logic                       ready_out,
  output T                           instr_out,
  output T                           pc_out,
  output logic                       valid_out,
  input  logic                       ready_in,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  localparam logic [PtrW-1:0] LastPtr = PtrW'(DEPTH - 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);

  T instr_mem [DEPTH];
  T pc_mem    [DEPTH];

  logic [PtrW-1:0] head_q, head_d;
  logic [PtrW-1:0] tail_q, tail_d;
  logic [CntW-1:0] count_q, count_d;

  logic push;
  logic pop;

  // Handshake flags derive only from the count register, never from the inputs.
  assign ready_out = (count_q != FullCnt);
  assign valid_out = (count_q != '0);
  assign count     = count_q;

  assign instr_out = instr_mem[head_q];
  assign pc_out    = pc_mem[head_q];

  assign push = valid_in & ready_out & ~flush;
  assign pop  = valid_out & ready_in & ~flush;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
    return (ptr == LastPtr) ? '0 : ptr + 1'b1;
  endfunction

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) tail_d = ptr_inc(tail_q);
      if (pop)  head_d = ptr_inc(head_q);
      unique case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload storage is deliberately unreset; it is only observed while valid_out is high.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[tail_q] <= instr_in;
      pc_mem[tail_q]    <= pc_in;
    end
  end

endmodule
